alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised sequential ALU; the next generation of the team's 4-bit registered ALU.
- Generalised to WIDTH bits.
- Adds iterative shifts (1 bit/cycle) and a shift-add multiplier.
- Wraps everything in a valid/ready handshake on both sides, with ZCNV flags registered alongside each result.
- Sits between the operand/decode stage and writeback; one operation in flight at a time.

Parameters:
- WIDTH, 8, operand/result width; integer >= 4.
- SHW, $clog2(WIDTH), shift-amount width (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands/opcode valid.
- in_ready  out  1  block can accept an operation.
- op  in  4  opcode (see Behaviour).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B; low SHW bits give the shift amount for shift ops.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer accepts result.
- g  out  WIDTH  result.
- zcnv  out  4  flags {Z,C,N,V}, bit 3 = Z.
- err  out  1  illegal opcode flagged with this result.
- busy  out  1  high in EXEC or DONE.

Behaviour:
- Reset (synchronous, active-high):
  - State -> IDLE.
  - g, zcnv, err, out_valid, busy = 0; in_ready = 1 in the cycle after reset.
  - Applies mid-operation: any in-flight op is discarded and no result is emitted.
- States:
  - IDLE: in_ready = 1.
  - EXEC: iterative ops.
  - DONE: out_valid = 1.
- Acceptance: on an edge with in_valid && in_ready, capture a, b, op.
  - Single-cycle ops go -> DONE with g/zcnv written at that edge.
  - SLL/SRL/SRA with amount s > 0, and MUL, go -> EXEC.
  - A shift with s = 0 goes directly to DONE: g = a, C = 0.
- EXEC:
  - Shifts: one bit per cycle, s cycles, then -> DONE.
  - MUL: WIDTH cycles of unsigned shift-add into a 2*WIDTH product, then -> DONE.
  - An internal SHW+1-bit counter tracks the remaining iterations.
- Latency (acceptance edge to first cycle out_valid = 1):
  - 1 cycle for single-cycle ops.
  - s+1 cycles for shifts.
  - WIDTH+1 cycles for MUL.
- DONE:
  - g, zcnv, err are held stable while out_valid && !out_ready.
  - On out_valid && out_ready -> IDLE; in_ready rises the following cycle. No overlap of DONE and acceptance.
- Opcodes and results:
  - 0000 ADD: {C,g} = a + b.
  - 0001 SUB: {C,g} = a + ~b + 1; C = 1 means no borrow.
  - 0010 AND; 0011 OR; 0100 XOR; 0101 NOR.
  - 0110 SLL; 0111 SRL; 1000 SRA (sign fill), each by b[SHW-1:0].
  - 1001 MUL: g = low WIDTH bits of product.
  - 1010-1111 illegal: g = 0, zcnv = 0, err = 1; single-cycle latency.
- Flags:
  - Z = (g == 0) for all legal ops.
  - N = g[WIDTH-1] for all legal ops.
  - ADD: V = (a[MSB] == b[MSB]) && (g[MSB] != a[MSB]).
  - SUB: V = (a[MSB] != b[MSB]) && (g[MSB] != a[MSB]).
  - Logic ops: C = V = 0.
  - Shifts: C = last bit shifted out (0 when s = 0); V = 0.
  - MUL: C = (upper WIDTH bits of product != 0); V = 0.
- Arithmetic is modulo 2^WIDTH; no saturation.
- in_valid while busy is ignored, and inputs are not sampled.
- out_ready while IDLE/EXEC is ignored.

Test Plan:
- WIDTH=8, ADD a=0x7F b=0x01 -> out_valid 1 cycle after accept; g=0x80, zcnv=Z0 C0 N1 V1 (4'b0011).
- SUB a=0x05 b=0x05 -> g=0x00, zcnv=4'b1100. SUB a=0x00 b=0x01 -> g=0xFF, zcnv=4'b0010.
- Shifts:
  - SRA a=0x85 b=0x01 -> g=0xC2, C=1, latency 2.
  - SRA a=0x80 b=0x03 -> g=0xF0, C=0, N=1, latency 4.
  - SLL with b=0x00 -> g=a, C=0, latency 1.
- MUL a=0x10 b=0x10 -> g=0x00, zcnv=4'b1100, latency 9. MUL a=0x0F b=0x0F -> g=0xE1, zcnv=4'b0010.
- Backpressure: hold out_ready=0 for 5 cycles after ADD result.
  - Required: g/zcnv stable, in_ready=0, and a second in_valid pulse is ignored.
  - After out_ready=1 for one cycle: in_ready=1 next cycle.
- Reset asserted 3 cycles into MUL -> next cycle state IDLE, out_valid=0, g=0, zcnv=0, busy=0; no stale result emitted afterwards. Illegal op 1100 -> err=1, g=0.

Source files
------------

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Brief    : WIDTH-bit sequential ALU with valid/ready handshake, iterative
//            shifts (1 bit/cycle), shift-add multiplier and registered ZCNV.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] g,
    output logic [3:0]       zcnv,
    output logic             err,
    output logic             busy
);

    localparam int MSB = WIDTH - 1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOR = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    localparam logic [SHW:0] CNT_MUL = (SHW+1)'(WIDTH);
    localparam logic [SHW:0] CNT_ONE = (SHW+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state;
    logic [3:0]           op_q;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     shreg;
    logic [2*WIDTH-1:0]   prod;
    logic [SHW:0]         cnt;

    logic [WIDTH:0]       sum_add;
    logic [WIDTH:0]       sum_sub;
    logic [WIDTH-1:0]     sc_g;
    logic                 sc_c;
    logic                 sc_v;
    logic                 sc_err;
    logic [SHW-1:0]       shamt;
    logic                 is_iter;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   prod_nxt;
    logic [WIDTH-1:0]     sh_nxt;
    logic                 sh_c;

    function automatic logic [3:0] flags(input logic [WIDTH-1:0] r,
                                         input logic c, input logic v);
        return {(r == '0), c, r[MSB], v};
    endfunction

    // Ops that finish at the acceptance edge; shifts only land here with s = 0
    always_comb begin
        sum_add = {1'b0, a} + {1'b0, b};
        sum_sub = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        shamt   = b[SHW-1:0];
        is_iter = (op == OP_MUL) ||
                  (((op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA)) && (shamt != '0));
        sc_g    = '0;
        sc_c    = 1'b0;
        sc_v    = 1'b0;
        sc_err  = 1'b0;
        case (op)
            OP_ADD: begin
                sc_g = sum_add[MSB:0];
                sc_c = sum_add[WIDTH];
                sc_v = (a[MSB] == b[MSB]) && (sum_add[MSB] != a[MSB]);
            end
            OP_SUB: begin
                sc_g = sum_sub[MSB:0];
                sc_c = sum_sub[WIDTH];
                sc_v = (a[MSB] != b[MSB]) && (sum_sub[MSB] != a[MSB]);
            end
            OP_AND:                 sc_g = a & b;
            OP_OR:                  sc_g = a | b;
            OP_XOR:                 sc_g = a ^ b;
            OP_NOR:                 sc_g = ~(a | b);
            OP_SLL, OP_SRL, OP_SRA: sc_g = a;
            OP_MUL:                 sc_g = '0;
            default:                sc_err = 1'b1;
        endcase
    end

    // One iteration step: shift-add on the product, or a 1-bit shift
    always_comb begin
        mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} +
                   (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        prod_nxt = {mul_sum, prod[WIDTH-1:1]};
        sh_nxt   = shreg;
        sh_c     = 1'b0;
        case (op_q)
            OP_SLL: begin
                sh_nxt = {shreg[MSB-1:0], 1'b0};
                sh_c   = shreg[MSB];
            end
            OP_SRL: begin
                sh_nxt = {1'b0, shreg[MSB:1]};
                sh_c   = shreg[0];
            end
            OP_SRA: begin
                sh_nxt = {shreg[MSB], shreg[MSB:1]};
                sh_c   = shreg[0];
            end
            default: begin
                sh_nxt = shreg;
                sh_c   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            g         <= '0;
            zcnv      <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            op_q      <= '0;
            mcand     <= '0;
            shreg     <= '0;
            prod      <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q     <= op;
                        mcand    <= a;
                        shreg    <= a;
                        prod     <= {{WIDTH{1'b0}}, b};
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (is_iter) begin
                            state <= S_EXEC;
                            cnt   <= (op == OP_MUL) ? CNT_MUL : {1'b0, shamt};
                        end else begin
                            state     <= S_DONE;
                            out_valid <= 1'b1;
                            g         <= sc_g;
                            zcnv      <= sc_err ? 4'b0000 : flags(sc_g, sc_c, sc_v);
                            err       <= sc_err;
                        end
                    end
                end
                S_EXEC: begin
                    cnt <= cnt - CNT_ONE;
                    if (op_q == OP_MUL) begin
                        prod <= prod_nxt;
                    end else begin
                        shreg <= sh_nxt;
                    end
                    if (cnt == CNT_ONE) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        err       <= 1'b0;
                        if (op_q == OP_MUL) begin
                            g    <= prod_nxt[MSB:0];
                            zcnv <= flags(prod_nxt[MSB:0], |prod_nxt[2*WIDTH-1:WIDTH], 1'b0);
                        end else begin
                            g    <= sh_nxt;
                            zcnv <= flags(sh_nxt, sh_c, 1'b0);
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_seq
// Brief    : Self-checking bench for alu_seq (WIDTH=8) with a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] g;
    logic [3:0]   zcnv;
    logic         err;
    logic         busy;

    int           tests = 0;
    int           fails = 0;
    logic         exp_pending = 1'b0;
    logic [W-1:0] exp_g;
    logic [3:0]   exp_zcnv;
    logic         exp_err;
    int           exp_lat;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .g         (g),
        .zcnv      (zcnv),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Reference results from plain integer arithmetic
    task automatic model(input logic [3:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb,
                         output logic [W-1:0] mg, output logic [3:0] mz,
                         output logic me, output int ml);
        int s, ua, ub, sa, sb, r;
        logic c, v;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        s  = ub % W;
        c  = 1'b0;
        v  = 1'b0;
        me = 1'b0;
        ml = 1;
        mg = '0;
        case (mop)
            4'd0: begin
                r  = ua + ub;
                mg = W'(r);
                c  = (r >= (1 << W));
                v  = ((sa + sb) > ((1 << (W-1)) - 1)) || ((sa + sb) < -(1 << (W-1)));
            end
            4'd1: begin
                r  = ua - ub;
                mg = W'(r);
                c  = (ua >= ub);
                v  = ((sa - sb) > ((1 << (W-1)) - 1)) || ((sa - sb) < -(1 << (W-1)));
            end
            4'd2: mg = ma & mb;
            4'd3: mg = ma | mb;
            4'd4: mg = ma ^ mb;
            4'd5: mg = ~(ma | mb);
            4'd6: begin
                mg = W'(ua << s);
                c  = (s > 0) && (((ua >> (W - s)) & 1) != 0);
                ml = s + 1;
            end
            4'd7: begin
                mg = W'(ua >> s);
                c  = (s > 0) && (((ua >> (s - 1)) & 1) != 0);
                ml = s + 1;
            end
            4'd8: begin
                mg = W'(sa >>> s);
                c  = (s > 0) && (((ua >> (s - 1)) & 1) != 0);
                ml = s + 1;
            end
            4'd9: begin
                r  = ua * ub;
                mg = W'(r);
                c  = (r >= (1 << W));
                ml = W + 1;
            end
            default: me = 1'b1;
        endcase
        mz = me ? 4'b0000 : {(mg == '0), c, mg[W-1], v};
    endtask

    // Every cycle a result is presented it must match the pending expectation
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (!exp_pending) begin
                chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
            end else begin
                chk("model_g",    {24'd0, g},    {24'd0, exp_g});
                chk("model_zcnv", {28'd0, zcnv}, {28'd0, exp_zcnv});
                chk("model_err",  {31'd0, err},  {31'd0, exp_err});
            end
        end
    end

    task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        int n;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("accept_timeout", {31'd0, in_ready}, 32'd1);
        op = o;
        a  = x;
        b  = y;
        in_valid = 1'b1;
        model(o, x, y, exp_g, exp_zcnv, exp_err, exp_lat);
        exp_pending = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        op = 4'($urandom);
        a  = W'($urandom);
        b  = W'($urandom);
    endtask

    task automatic wait_result(output int lat);
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, exp_lat);
    endtask

    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input bit lit, input logic [W-1:0] lg, input logic [3:0] lz,
                          input logic le, input int llat);
        int lat;
        issue(o, x, y);
        wait_result(lat);
        if (lit) begin
            chk("lit_g",       {24'd0, g},    {24'd0, lg});
            chk("lit_zcnv",    {28'd0, zcnv}, {28'd0, lz});
            chk("lit_err",     {31'd0, err},  {31'd0, le});
            chk("lit_latency", lat, llat);
        end
        @(negedge clk);
        exp_pending = 1'b0;
        chk("idle_after_handoff", {29'd0, out_valid, in_ready, busy}, 32'b010);
    endtask

    initial begin
        int lat;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op = '0;
        a  = '0;
        b  = '0;
        repeat (2) @(negedge clk);
        chk("reset_state", {15'd0, out_valid, in_ready, busy, err, zcnv, g},
            {15'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 8'h00});
        reset = 1'b0;

        // Hand-computed vectors
        run_op(4'd0, 8'h7F, 8'h01, 1, 8'h80, 4'b0011, 1'b0, 1);
        run_op(4'd1, 8'h05, 8'h05, 1, 8'h00, 4'b1100, 1'b0, 1);
        run_op(4'd1, 8'h00, 8'h01, 1, 8'hFF, 4'b0010, 1'b0, 1);
        run_op(4'd8, 8'h85, 8'h01, 1, 8'hC2, 4'b0110, 1'b0, 2);
        run_op(4'd8, 8'h80, 8'h03, 1, 8'hF0, 4'b0010, 1'b0, 4);
        run_op(4'd6, 8'h5A, 8'h00, 1, 8'h5A, 4'b0000, 1'b0, 1);
        run_op(4'd9, 8'h10, 8'h10, 1, 8'h00, 4'b1100, 1'b0, 9);
        run_op(4'd9, 8'h0F, 8'h0F, 1, 8'hE1, 4'b0010, 1'b0, 9);
        run_op(4'hC, 8'h12, 8'h34, 1, 8'h00, 4'b0000, 1'b1, 1);

        // Model-only vectors
        run_op(4'd2, 8'hF0, 8'h3C, 0, '0, '0, 1'b0, 0);
        run_op(4'd3, 8'h0F, 8'hA0, 0, '0, '0, 1'b0, 0);
        run_op(4'd4, 8'hFF, 8'hFF, 0, '0, '0, 1'b0, 0);
        run_op(4'd5, 8'h00, 8'h00, 0, '0, '0, 1'b0, 0);
        run_op(4'd6, 8'h81, 8'h07, 0, '0, '0, 1'b0, 0);
        run_op(4'd6, 8'h0F, 8'hF9, 0, '0, '0, 1'b0, 0);
        run_op(4'd7, 8'h81, 8'h01, 0, '0, '0, 1'b0, 0);
        run_op(4'd8, 8'h7F, 8'h05, 0, '0, '0, 1'b0, 0);
        run_op(4'd0, 8'hFF, 8'h01, 0, '0, '0, 1'b0, 0);
        run_op(4'd1, 8'h80, 8'h01, 0, '0, '0, 1'b0, 0);
        run_op(4'd9, 8'hFF, 8'hFF, 0, '0, '0, 1'b0, 0);
        run_op(4'd9, 8'h0D, 8'hB7, 0, '0, '0, 1'b0, 0);
        run_op(4'hA, 8'h01, 8'h02, 0, '0, '0, 1'b0, 0);
        run_op(4'hF, 8'hFF, 8'hFF, 0, '0, '0, 1'b0, 0);

        // Backpressure: result held, second request ignored
        out_ready = 1'b0;
        issue(4'd0, 8'h7F, 8'h01);
        wait_result(lat);
        for (int i = 0; i < 5; i++) begin
            chk("bp_held", {29'd0, out_valid, in_ready, busy}, 32'b101);
            chk("bp_g", {24'd0, g}, 32'h80);
            if (i == 1) begin
                in_valid = 1'b1;
                op = 4'd1;
                a  = 8'h33;
                b  = 8'h11;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        exp_pending = 1'b0;
        chk("bp_release", {30'd0, in_ready, out_valid}, 32'b10);
        repeat (12) @(negedge clk);

        // Reset three cycles into a multiply
        issue(4'd9, 8'h0F, 8'h0F);
        repeat (2) @(negedge clk);
        exp_pending = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("mid_reset", {15'd0, out_valid, in_ready, busy, err, zcnv, g},
            {15'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 8'h00});
        reset = 1'b0;
        repeat (15) @(negedge clk);
        chk("no_stale_result", {31'd0, out_valid}, 32'd0);

        run_op(4'd0, 8'h22, 8'h33, 0, '0, '0, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
